// File: rtl/tlcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tlcd_bus_arbiter
//
// Shares one character-LCD bus between two independent LCD masters using a
// request/grant handshake. Ownership only changes after the owner has dropped
// its request with its E line low, and every release is followed by an idle
// guard gap before the bus can be granted again.
//
// Parameters:
//   GUARD_CYCLES  idle bus cycles after each release (1..255)
//   ROUND_ROBIN   1 = alternate winner on contention, 0 = requester 0 wins
//
// Ports:
//   CLK                      system clock, rising edge
//   RESETN                   asynchronous active-low reset
//   REQ0/E0/RS0/RW0/DATA0    requester 0 request and LCD lines
//   REQ1/E1/RS1/RW1/DATA1    requester 1 request and LCD lines
//   GNT0/GNT1                registered grants, never both high
//   TLCD_E/RS/RW/DATA        registered LCD pins
//   BUSY                     high while a requester owns the bus or in guard
// ---------------------------------------------------------------------------
module tlcd_bus_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter bit          ROUND_ROBIN  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       E0,
  input  logic       RS0,
  input  logic       RW0,
  input  logic [7:0] DATA0,
  input  logic       REQ1,
  input  logic       E1,
  input  logic       RS1,
  input  logic       RW1,
  input  logic [7:0] DATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1,
    ST_GUARD
  } state_t;

  // The guard counter counts down to zero, so it is loaded one short of the
  // number of guard cycles wanted.
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_t     state;
  logic       last;
  logic [7:0] guard_cnt;
  logic       pick1;

  // Winner selection when arbitrating from IDLE. On contention with round
  // robin enabled, the requester that did not own the bus last time wins.
  always_comb begin
    pick1 = 1'b0;
    if (REQ0 && REQ1) begin
      pick1 = ROUND_ROBIN ? ~last : 1'b0;
    end else begin
      pick1 = REQ1;
    end
  end

  // Arbitration state machine with all pin and grant outputs registered.
  // The owner's lines are forwarded one cycle late; the owner may only leave
  // once its request and its E line are both low, so E pulses are never cut.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      guard_cnt <= 8'd0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      TLCD_E    <= 1'b0;
      TLCD_RS   <= 1'b0;
      TLCD_RW   <= 1'b0;
      TLCD_DATA <= 8'h00;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          TLCD_E    <= 1'b0;
          TLCD_RS   <= 1'b0;
          TLCD_RW   <= 1'b0;
          TLCD_DATA <= 8'h00;
          if (REQ0 || REQ1) begin
            BUSY <= 1'b1;
            if (pick1) begin
              state <= ST_OWN1;
              GNT1  <= 1'b1;
              last  <= 1'b1;
            end else begin
              state <= ST_OWN0;
              GNT0  <= 1'b1;
              last  <= 1'b0;
            end
          end
        end

        ST_OWN0: begin
          if (!REQ0 && !E0) begin
            state     <= ST_GUARD;
            guard_cnt <= GUARD_LOAD;
            GNT0      <= 1'b0;
            TLCD_E    <= 1'b0;
            TLCD_RS   <= 1'b0;
            TLCD_RW   <= 1'b0;
            TLCD_DATA <= 8'h00;
          end else begin
            TLCD_E    <= E0;
            TLCD_RS   <= RS0;
            TLCD_RW   <= RW0;
            TLCD_DATA <= DATA0;
          end
        end

        ST_OWN1: begin
          if (!REQ1 && !E1) begin
            state     <= ST_GUARD;
            guard_cnt <= GUARD_LOAD;
            GNT1      <= 1'b0;
            TLCD_E    <= 1'b0;
            TLCD_RS   <= 1'b0;
            TLCD_RW   <= 1'b0;
            TLCD_DATA <= 8'h00;
          end else begin
            TLCD_E    <= E1;
            TLCD_RS   <= RS1;
            TLCD_RW   <= RW1;
            TLCD_DATA <= DATA1;
          end
        end

        ST_GUARD: begin
          TLCD_E    <= 1'b0;
          TLCD_RS   <= 1'b0;
          TLCD_RW   <= 1'b0;
          TLCD_DATA <= 8'h00;
          if (guard_cnt == 8'd0) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          GNT0      <= 1'b0;
          GNT1      <= 1'b0;
          TLCD_E    <= 1'b0;
          TLCD_RS   <= 1'b0;
          TLCD_RW   <= 1'b0;
          TLCD_DATA <= 8'h00;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlcd_bus_arbiter
//
// Drives two arbiter instances from the same inputs: one with round-robin
// priority and one with fixed priority. Expected output vectors are queued
// as each step's stimulus is applied and popped after the following edge.
// Output vector layout: {GNT0, GNT1, BUSY, TLCD_E, TLCD_RS, TLCD_RW, DATA}.
// ---------------------------------------------------------------------------
module tb_tlcd_bus_arbiter;

  localparam int unsigned GUARD = 4;

  logic       CLK;
  logic       RESETN;
  logic       REQ0, E0, RS0, RW0;
  logic [7:0] DATA0;
  logic       REQ1, E1, RS1, RW1;
  logic [7:0] DATA1;

  logic       gnt0Rr, gnt1Rr, eRr, rsRr, rwRr, busyRr;
  logic [7:0] dataRr;
  logic       gnt0Fp, gnt1Fp, eFp, rsFp, rwFp, busyFp;
  logic [7:0] dataFp;

  typedef struct {
    string       tag;
    bit          sel;
    logic [13:0] val;
  } expT;

  expT expQ[$];
  int  testCount = 0;
  int  failCount = 0;

  tlcd_bus_arbiter #(.GUARD_CYCLES(GUARD), .ROUND_ROBIN(1'b1)) dutRr (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .E0(E0), .RS0(RS0), .RW0(RW0), .DATA0(DATA0),
    .REQ1(REQ1), .E1(E1), .RS1(RS1), .RW1(RW1), .DATA1(DATA1),
    .GNT0(gnt0Rr), .GNT1(gnt1Rr),
    .TLCD_E(eRr), .TLCD_RS(rsRr), .TLCD_RW(rwRr), .TLCD_DATA(dataRr),
    .BUSY(busyRr)
  );

  tlcd_bus_arbiter #(.GUARD_CYCLES(GUARD), .ROUND_ROBIN(1'b0)) dutFp (
    .CLK(CLK), .RESETN(RESETN),
    .REQ0(REQ0), .E0(E0), .RS0(RS0), .RW0(RW0), .DATA0(DATA0),
    .REQ1(REQ1), .E1(E1), .RS1(RS1), .RW1(RW1), .DATA1(DATA1),
    .GNT0(gnt0Fp), .GNT1(gnt1Fp),
    .TLCD_E(eFp), .TLCD_RS(rsFp), .TLCD_RW(rwFp), .TLCD_DATA(dataFp),
    .BUSY(busyFp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [13:0] outVec(input logic g0, input logic g1,
                                         input logic busy, input logic e,
                                         input logic rs, input logic rw,
                                         input logic [7:0] d);
    return {g0, g1, busy, e, rs, rw, d};
  endfunction

  task automatic applyStimulus(input logic r0, input logic e0v, input logic rs0v,
                               input logic rw0v, input logic [7:0] d0,
                               input logic r1, input logic e1v, input logic rs1v,
                               input logic rw1v, input logic [7:0] d1);
    REQ0 = r0; E0 = e0v; RS0 = rs0v; RW0 = rw0v; DATA0 = d0;
    REQ1 = r1; E1 = e1v; RS1 = rs1v; RW1 = rw1v; DATA1 = d1;
  endtask

  task automatic pushExp(input string tag, input bit sel, input logic [13:0] v);
    expT ent;
    ent.tag = tag;
    ent.sel = sel;
    ent.val = v;
    expQ.push_back(ent);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput();
    expT         ent;
    logic [13:0] obs;
    testCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty: observed=no entry expected=queued entry");
    end else begin
      ent = expQ.pop_front();
      obs = ent.sel ? {gnt0Fp, gnt1Fp, busyFp, eFp, rsFp, rwFp, dataFp}
                    : {gnt0Rr, gnt1Rr, busyRr, eRr, rsRr, rwRr, dataRr};
      assert (obs === ent.val) else begin
        failCount++;
        $error("[TB] FAIL %s: observed=%h expected=%h", ent.tag, obs, ent.val);
      end
    end
  endtask

  initial begin
    logic [13:0] zero;
    logic [13:0] guardV;
    zero   = outVec(0, 0, 0, 0, 0, 0, 8'h00);
    guardV = outVec(0, 0, 1, 0, 0, 0, 8'h00);

    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    RESETN = 1'b0;
    #2;
    pushExp("reset_rr", 0, zero);
    checkOutput();
    pushExp("reset_fp", 1, zero);
    checkOutput();
    tick();
    tick();
    RESETN = 1'b1;

    // Single grant and one-cycle forwarding latency
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    pushExp("grant0", 0, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput();
    pushExp("own0_hold", 0, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput();
    applyStimulus(1, 1, 1, 0, 8'h41, 0, 0, 0, 0, 8'h00);
    pushExp("fwd_41", 0, outVec(1, 0, 1, 1, 1, 0, 8'h41));
    tick(); checkOutput();

    // Non-owner lines must never reach the pins
    applyStimulus(1, 0, 0, 0, 8'h12, 1, 1, 1, 1, 8'hFF);
    pushExp("isolate_a", 0, outVec(1, 0, 1, 0, 0, 0, 8'h12));
    tick(); checkOutput();
    applyStimulus(1, 1, 0, 0, 8'h34, 1, 0, 1, 1, 8'hFF);
    pushExp("isolate_b", 0, outVec(1, 0, 1, 1, 0, 0, 8'h34));
    tick(); checkOutput();

    // Request dropped while E is high: pulse completes before release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 8'h56, 1, i[0], 0, 0, 8'hFF);
      pushExp("e_protect", 0, outVec(1, 0, 1, 1, 0, 0, 8'h56));
      tick(); checkOutput();
    end
    applyStimulus(0, 0, 0, 0, 8'h56, 1, 0, 0, 0, 8'hFF);
    pushExp("release_guard", 0, guardV);
    tick(); checkOutput();
    for (int i = 1; i < GUARD; i++) begin
      pushExp("guard_gap", 0, guardV);
      tick(); checkOutput();
    end
    pushExp("idle_after_guard", 0, zero);
    tick(); checkOutput();
    pushExp("grant1_after_idle", 0, outVec(0, 1, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput();

    // Mid-write asynchronous reset while requester 1 owns the bus
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h9A);
    pushExp("own1_fwd", 0, outVec(0, 1, 1, 1, 0, 1, 8'h9A));
    tick(); checkOutput();
    #2;
    RESETN = 1'b0;
    #1;
    pushExp("async_reset_rr", 0, zero);
    checkOutput();
    pushExp("async_reset_fp", 1, zero);
    checkOutput();
    tick();
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    RESETN = 1'b1;
    pushExp("post_reset_rr_gnt0", 0, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    pushExp("post_reset_fp_gnt0", 1, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput(); checkOutput();

    // Contention: requester 0 releases then re-requests during guard
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    pushExp("cont_guard_rr", 0, guardV);
    pushExp("cont_guard_fp", 1, guardV);
    tick(); checkOutput(); checkOutput();
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    for (int i = 1; i < GUARD; i++) begin
      pushExp("cont_guard_gap", 0, guardV);
      tick(); checkOutput();
    end
    pushExp("cont_idle", 0, zero);
    tick(); checkOutput();
    pushExp("rr_alternates_gnt1", 0, outVec(0, 1, 1, 0, 0, 0, 8'h00));
    pushExp("fp_keeps_gnt0", 1, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput(); checkOutput();

    // Fixed priority: requester 0 wins again while both keep requesting
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    pushExp("fp_guard", 1, guardV);
    tick(); checkOutput();
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    for (int i = 1; i < GUARD; i++) begin
      pushExp("fp_guard_gap", 1, guardV);
      tick(); checkOutput();
    end
    pushExp("fp_idle", 1, zero);
    tick(); checkOutput();
    pushExp("fp_gnt0_again", 1, outVec(1, 0, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput();

    // Requester 1 only gets the bus once requester 0 stops asking
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    pushExp("fp_release_guard", 1, guardV);
    tick(); checkOutput();
    for (int i = 1; i < GUARD; i++) begin
      pushExp("fp_release_gap", 1, guardV);
      tick(); checkOutput();
    end
    pushExp("fp_release_idle", 1, zero);
    tick(); checkOutput();
    pushExp("fp_gnt1_finally", 1, outVec(0, 1, 1, 0, 0, 0, 8'h00));
    tick(); checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
